me_frame_feeder: RTL and testbench

- Upstream stage of the motion-estimation block.
- Buffers one current frame and one reference frame, both streamed in raster order.
- For every 4x4 current block it emits the 16 block pixels, then the clamped 8x8 search area, using the block_valid/area_valid protocol the ME stage consumes.
- Waits for the ME result handshake before sending the next block, and flags completion of the frame.

---
 rtl/me_frame_feeder.sv | 221 ++++++++++++++++++++++
 tb/tb_me_frame_feeder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/me_frame_feeder.sv
// Motion-estimation front end: buffers a current and a reference frame, then
// streams each 4x4 current block followed by its clamped 8x8 search area.
// Before moving to the next block it waits for the ME result handshake.
module me_frame_feeder #(
    parameter int FRAME_W = 16,
    parameter int FRAME_H = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic [7:0]                             in_data,
    output logic                                   in_ready,
    input  logic                                   me_out_valid,
    output logic                                   block_valid,
    output logic                                   area_valid,
    output logic [7:0]                             out_data,
    output logic [$clog2(FRAME_W*FRAME_H/16)-1:0] blk_idx,
    output logic                                   frame_done
);

    localparam int NPIX = FRAME_W * FRAME_H;
    localparam int AW   = $clog2(NPIX);
    localparam int NBLK = NPIX / 16;
    localparam int BW   = $clog2(NBLK);
    localparam int BXN  = FRAME_W / 4;
    localparam int BYN  = FRAME_H / 4;
    localparam int BXW  = $clog2(BXN);
    localparam int BYW  = $clog2(BYN);

    typedef enum logic [2:0] {
        LOAD_CUR,
        LOAD_REF,
        SEND_BLK,
        SEND_AREA,
        WAIT_ME
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   ld_cnt, ld_cnt_n;
    logic [5:0]      pix, pix_n, pix_inc;
    logic [BXW-1:0]  bx, bx_n, bx_adv;
    logic [BYW-1:0]  by, by_n, by_adv;
    logic            seen_rise, seen_rise_n;
    logic            in_ready_n, block_valid_n, area_valid_n, frame_done_n;
    logic [7:0]      out_data_n;
    logic [BW-1:0]   blk_idx_n;
    logic            wr_cur, wr_ref, ld_last, blk_last;

    logic [7:0] cur_mem [NPIX];
    logic [7:0] ref_mem [NPIX];

    // Linear address of pixel p (row-major 4x4) of block (bx,by)
    function automatic logic [AW-1:0] blk_addr(input logic [BXW-1:0] cbx,
                                               input logic [BYW-1:0] cby,
                                               input logic [3:0]     p);
        int r, c;
        r = 4 * int'(cby) + int'(p[3:2]);
        c = 4 * int'(cbx) + int'(p[1:0]);
        return AW'(r * FRAME_W + c);
    endfunction

    // Linear address of search-area pixel p (row-major 8x8), edge-clamped
    function automatic logic [AW-1:0] area_addr(input logic [BXW-1:0] cbx,
                                                input logic [BYW-1:0] cby,
                                                input logic [5:0]     p);
        int r, c;
        r = 4 * int'(cby) - 2 + int'(p[5:3]);
        c = 4 * int'(cbx) - 2 + int'(p[2:0]);
        if (r < 0) r = 0;
        else if (r > FRAME_H - 1) r = FRAME_H - 1;
        if (c < 0) c = 0;
        else if (c > FRAME_W - 1) c = FRAME_W - 1;
        return AW'(r * FRAME_W + c);
    endfunction

    assign pix_inc  = pix + 6'd1;
    assign ld_last  = (ld_cnt == AW'(NPIX - 1));
    assign blk_last = (blk_idx == BW'(NBLK - 1));

    // Coordinates of the next block in raster order
    always_comb begin
        bx_adv = bx + 1'b1;
        by_adv = by;
        if (bx == BXW'(BXN - 1)) begin
            bx_adv = '0;
            by_adv = by + 1'b1;
        end
    end

    // Next state and next registered outputs; outputs are computed one cycle
    // ahead so every output port comes straight from a flop
    always_comb begin
        state_n       = state;
        ld_cnt_n      = ld_cnt;
        pix_n         = pix;
        bx_n          = bx;
        by_n          = by;
        seen_rise_n   = seen_rise;
        blk_idx_n     = blk_idx;
        out_data_n    = out_data;
        in_ready_n    = 1'b0;
        block_valid_n = 1'b0;
        area_valid_n  = 1'b0;
        frame_done_n  = 1'b0;
        wr_cur        = 1'b0;
        wr_ref        = 1'b0;
        case (state)
            LOAD_CUR: begin
                in_ready_n = 1'b1;
                if (in_valid) begin
                    wr_cur   = 1'b1;
                    ld_cnt_n = ld_last ? '0 : ld_cnt + 1'b1;
                    if (ld_last) state_n = LOAD_REF;
                end
            end
            LOAD_REF: begin
                in_ready_n = 1'b1;
                if (in_valid) begin
                    wr_ref   = 1'b1;
                    ld_cnt_n = ld_last ? '0 : ld_cnt + 1'b1;
                    if (ld_last) begin
                        state_n       = SEND_BLK;
                        in_ready_n    = 1'b0;
                        pix_n         = '0;
                        block_valid_n = 1'b1;
                        out_data_n    = cur_mem[blk_addr(bx, by, 4'd0)];
                    end
                end
            end
            SEND_BLK: begin
                if (pix == 6'd15) begin
                    // area follows with no gap: ME needs a contiguous burst
                    state_n      = SEND_AREA;
                    pix_n        = '0;
                    area_valid_n = 1'b1;
                    out_data_n   = ref_mem[area_addr(bx, by, 6'd0)];
                end else begin
                    pix_n         = pix_inc;
                    block_valid_n = 1'b1;
                    out_data_n    = cur_mem[blk_addr(bx, by, pix_inc[3:0])];
                end
            end
            SEND_AREA: begin
                if (pix == 6'd63) begin
                    state_n     = WAIT_ME;
                    pix_n       = '0;
                    seen_rise_n = 1'b0;
                end else begin
                    pix_n        = pix_inc;
                    area_valid_n = 1'b1;
                    out_data_n   = ref_mem[area_addr(bx, by, pix_inc)];
                end
            end
            WAIT_ME: begin
                if (!seen_rise && me_out_valid) begin
                    seen_rise_n = 1'b1;
                end else if (seen_rise && !me_out_valid) begin
                    seen_rise_n = 1'b0;
                    if (blk_last) begin
                        state_n      = LOAD_CUR;
                        blk_idx_n    = '0;
                        bx_n         = '0;
                        by_n         = '0;
                        frame_done_n = 1'b1;
                        in_ready_n   = 1'b1;
                    end else begin
                        state_n       = SEND_BLK;
                        blk_idx_n     = blk_idx + 1'b1;
                        bx_n          = bx_adv;
                        by_n          = by_adv;
                        pix_n         = '0;
                        block_valid_n = 1'b1;
                        out_data_n    = cur_mem[blk_addr(bx_adv, by_adv, 4'd0)];
                    end
                end
            end
            default: begin
                state_n    = LOAD_CUR;
                in_ready_n = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD_CUR;
            ld_cnt      <= '0;
            pix         <= '0;
            bx          <= '0;
            by          <= '0;
            seen_rise   <= 1'b0;
            in_ready    <= 1'b1;
            block_valid <= 1'b0;
            area_valid  <= 1'b0;
            out_data    <= '0;
            blk_idx     <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            ld_cnt      <= ld_cnt_n;
            pix         <= pix_n;
            bx          <= bx_n;
            by          <= by_n;
            seen_rise   <= seen_rise_n;
            in_ready    <= in_ready_n;
            block_valid <= block_valid_n;
            area_valid  <= area_valid_n;
            out_data    <= out_data_n;
            blk_idx     <= blk_idx_n;
            frame_done  <= frame_done_n;
        end
    end

    // Frame buffers: written only while loading, contents need no reset
    always_ff @(posedge clk) begin
        if (wr_cur) cur_mem[ld_cnt] <= in_data;
        if (wr_ref) ref_mem[ld_cnt] <= in_data;
    end

endmodule

// File: tb/tb_me_frame_feeder.sv
// Bench for me_frame_feeder: loads frames, checks every streamed block and
// search area against a pixel-array reference model, exercises the ME
// handshake, frame completion, ignored input and asynchronous reset.
module tb_me_frame_feeder;

    localparam int W    = 16;
    localparam int H    = 16;
    localparam int NPIX = W * H;
    localparam int NBLK = NPIX / 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       me_out_valid = 1'b0;
    logic       in_ready, block_valid, area_valid, frame_done;
    logic [7:0] out_data;
    logic [3:0] blk_idx;

    int n_chk = 0;
    int n_bad = 0;
    int cur_m [H][W];
    int ref_m [H][W];

    me_frame_feeder #(.FRAME_W(W), .FRAME_H(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .me_out_valid (me_out_valid),
        .block_valid  (block_valid),
        .area_valid   (area_valid),
        .out_data     (out_data),
        .blk_idx      (blk_idx),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampv(input int v, input int mx);
        return (v < 0) ? 0 : ((v > mx - 1) ? mx - 1 : v);
    endfunction

    // k = 0..15 block pixels, 16..79 search-area pixels
    function automatic int exp_pix(input int b, input int k);
        int bx, by, i, j;
        bx = b % (W / 4);
        by = b / (W / 4);
        if (k < 16) return cur_m[4*by + k/4][4*bx + k%4];
        i = (k - 16) / 8;
        j = (k - 16) % 8;
        return ref_m[clampv(4*by - 2 + i, H)][clampv(4*bx - 2 + j, W)];
    endfunction

    task automatic set_frame_a();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                cur_m[r][c] = (16*r + c) % 256;
                ref_m[r][c] = (cur_m[r][c] + 1) % 256;
            end
    endtask

    task automatic set_frame_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                cur_m[r][c] = int'($urandom_range(0, 255));
                ref_m[r][c] = int'($urandom_range(0, 255));
            end
    endtask

    task automatic load_frame(input bit bubbles);
        int idx;
        bit v, rdy;
        idx = 0;
        while (idx < 2*NPIX) begin
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_data = 8'(idx < NPIX ? cur_m[idx/W][idx%W]
                                    : ref_m[(idx-NPIX)/W][(idx-NPIX)%W]);
            rdy = in_ready;
            if (!rdy) begin
                check("ld_rdy", rdy, 1);
                break;
            end
            tick();
            if (v) idx++;
        end
        in_valid = 1'b0;
        check("ld_end_rdy", in_ready, 0);
        check("ld_end_bv", block_valid, 1);
    endtask

    // Entered in the first block_valid cycle; ends in the first WAIT_ME cycle
    task automatic run_block(input int b, input bit toggle, input bit early, input int abort_at);
        check("blk_idx", blk_idx, b);
        for (int k = 0; k < 80; k++) begin
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_av", area_valid, 0);
                check("rst_bv", block_valid, 0);
                check("rst_rdy", in_ready, 1);
                check("rst_out", out_data, 0);
                check("rst_blk", blk_idx, 0);
                return;
            end
            check($sformatf("b%0d_vld", b), {block_valid, area_valid}, (k < 16) ? 2 : 1);
            check($sformatf("b%0d_px%0d", b, k), out_data, exp_pix(b, k));
            if (toggle) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom_range(0, 255));
            end
            if (early && k == 79) me_out_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("post_vld", {block_valid, area_valid}, 0);
        check("post_hold", out_data, exp_pix(b, 79));
    endtask

    task automatic handshake(input int b, input int gap, input bit early);
        if (early) begin
            tick();
            me_out_valid = 1'b0;
            check("hs_early", block_valid, 0);
        end else begin
            for (int g = 0; g < gap; g++) begin
                check("hs_wait", block_valid, 0);
                tick();
            end
            me_out_valid = 1'b1;
            check("hs_hi0", block_valid, 0);
            tick();
            check("hs_hi1", block_valid, 0);
            tick();
            me_out_valid = 1'b0;
            check("hs_lo", block_valid, 0);
        end
        tick();
        if (b == NBLK - 1) begin
            check("fd_pulse", frame_done, 1);
            check("fd_rdy", in_ready, 1);
            check("fd_blk", blk_idx, 0);
            check("fd_bv", block_valid, 0);
            tick();
            check("fd_clr", frame_done, 0);
            check("fd_rdy2", in_ready, 1);
        end else begin
            check("hs_next_bv", block_valid, 1);
            check("hs_next_blk", blk_idx, b + 1);
            check("hs_fd", frame_done, 0);
        end
    endtask

    task automatic run_frame(input bit bubbles, input bit vary);
        load_frame(bubbles);
        for (int b = 0; b < NBLK; b++) begin
            run_block(b, vary && (b == 1 || b == 5), vary && b == 3, -1);
            handshake(b, (b == 0) ? 20 : int'($urandom_range(3, 6)), vary && b == 3);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy0", in_ready, 1);
        check("rst_bv0", block_valid, 0);
        check("rst_av0", area_valid, 0);
        check("rst_out0", out_data, 0);
        check("rst_fd0", frame_done, 0);
        check("rst_blk0", blk_idx, 0);
        rst_n = 1'b1;

        // ramp frame at full rate, with ignored input and early ME handshake
        set_frame_a();
        run_frame(1'b0, 1'b1);

        // random frame with bubbled load right after frame_done
        set_frame_rand();
        run_frame(1'b1, 1'b0);

        // ramp frame again with bubbles, aborted by reset mid search area
        set_frame_a();
        load_frame(1'b1);
        for (int b = 0; b < 2; b++) begin
            run_block(b, 1'b0, 1'b0, -1);
            handshake(b, 3, 1'b0);
        end
        run_block(2, 1'b0, 1'b0, 30);
        #4 rst_n = 1'b1;
        tick();
        check("post_rst_rdy", in_ready, 1);
        check("post_rst_av", area_valid, 0);

        // fresh random frame after the abort
        set_frame_rand();
        run_frame(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
